// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive path.
//   rx_state_t : deframer state encoding
//   OSR        : oversample ticks per bit
//   MID_TICK   : start-bit sample point (tick count value)
//   LAST_TICK  : data/stop sample point (tick count value)
//   DATA_BITS  : payload bits per character
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int OSR       = 16;
  localparam int MID_TICK  = 7;
  localparam int LAST_TICK = 15;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO with registered read data.
//   clk_in, rst     : clock, synchronous active-high reset
//   wr_en, din      : push request/data (dropped while full)
//   rd_en, dout     : pop request (ignored while empty), data one cycle later
//   empty, full     : occupancy flags, evaluated before same-cycle pop
//   data_count      : number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      data_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign data_count = count;

  // Both qualifiers use the pre-update flags, so a push into a full FIFO is
  // lost even when a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 16x-oversampling 8N1 UART receiver feeding an internal byte FIFO.
//   clk_in, rst      : clock, synchronous active-high reset
//   rx_en            : one-cycle 16x baud tick
//   rx_serial_data   : asynchronous serial line, idle high
//   rd_en, dout      : FIFO read handshake (dout valid the cycle after)
//   empty, full      : FIFO occupancy flags
//   data_count       : bytes stored
//   rx_busy          : deframer not idle
//   frame_err        : sticky, stop bit sampled low
//   overflow         : sticky, good byte dropped on full FIFO
//   clr_err          : clears both sticky flags (a same-cycle set wins)
//
// Deframer states (advance only on rx_en):
//   state     | meaning
//   IDLE      | line high, waiting for a falling edge
//   START     | counting to mid start bit, rejecting glitches
//   DATA      | sampling 8 data bits at bit centre, LSB first
//   STOP      | sampling the stop bit, push or flag
//   WAIT_HIGH | framing error seen, wait for line to return high
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          rx_en,
  input  logic          rx_serial_data,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   data_count,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overflow,
  input  logic          clr_err
);

  logic                 sync1;
  logic                 rxs;

  rx_state_t            state, state_d;
  logic [3:0]           tcnt, tcnt_d;
  logic [2:0]           bcnt, bcnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 push;
  logic                 ferr_set;
  logic                 ovf_set;

  // Two-stage synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_serial_data;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      tcnt  <= tcnt_d;
      bcnt  <= bcnt_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state;
    tcnt_d   = tcnt;
    bcnt_d   = bcnt;
    shreg_d  = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    ovf_set  = 1'b0;
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (tcnt == 4'(MID_TICK)) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            tcnt_d = tcnt + 1'b1;
          end
        end
        DATA: begin
          // tcnt wraps 15 -> 0 so consecutive samples are OSR ticks apart.
          tcnt_d = tcnt + 1'b1;
          if (tcnt == 4'(LAST_TICK)) begin
            shreg_d = {rxs, shreg[DATA_BITS-1:1]};
            bcnt_d  = bcnt + 1'b1;
            if (bcnt == 3'(DATA_BITS-1)) begin
              state_d = STOP;
              tcnt_d  = '0;
            end
          end
        end
        STOP: begin
          if (tcnt == 4'(LAST_TICK)) begin
            if (rxs && !full) begin
              push    = 1'b1;
              state_d = IDLE;
            end else if (rxs) begin
              ovf_set = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end else begin
            tcnt_d = tcnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovf_set)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst        (rst),
    .wr_en      (push),
    .din        (shreg_d),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .data_count (data_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx_serial_data;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] data_count;
  logic       rx_busy;
  logic       frame_err;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] div = 2'd0;

  always #5 clk_in = ~clk_in;

  // 16x tick: one cycle in four.
  always @(posedge clk_in) div <= div + 2'd1;
  assign rx_en = (div == 2'd3);

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .rx_en          (rx_en),
    .rx_serial_data (rx_serial_data),
    .rd_en          (rd_en),
    .dout           (dout),
    .empty          (empty),
    .full           (full),
    .data_count     (data_count),
    .rx_busy        (rx_busy),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .clr_err        (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the next clk edge that carries a tick.
  task automatic wait_tick();
    @(negedge clk_in);
    while (!rx_en) @(negedge clk_in);
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_serial_data = b;
    repeat (n) wait_tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(stop, 16);
  endtask

  // Line falls right after tick T0; the stop bit is sampled on tick T0+153
  // (detect at +1, start sample at +9, then 9 samples 16 ticks apart).
  // sel=1 pulses rd_en on that cycle, sel=0 pulses clr_err.
  task automatic send_byte_evt(input logic [7:0] d, input logic stop, input logic sel);
    fork
      send_byte(d, stop);
      begin
        repeat (152) wait_tick();
        @(negedge clk_in);
        while (!rx_en) @(negedge clk_in);
        if (sel) rd_en = 1'b1;
        else     clr_err = 1'b1;
        @(posedge clk_in);
        #1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        if (sel) begin
          chk("simul_count", 32'(data_count), 32'd3);
          chk("simul_dout", 32'(dout), 32'h20);
        end
      end
    join
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    @(posedge clk_in);
    #1;
    rd_en = 1'b0;
    chk(tag, 32'(dout), 32'(exp));
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk_in);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},  32'(dout), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full), 32'd0);
    chk({tag, "_count"}, 32'(data_count), 32'd0);
    chk({tag, "_busy"},  32'(rx_busy), 32'd0);
    chk({tag, "_ferr"},  32'(frame_err), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    rx_serial_data = 1'b1;
    rd_en          = 1'b0;
    clr_err        = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (20) wait_tick();

    // Single byte.
    chk("single_empty_pre", 32'(empty), 32'd1);
    send_byte(8'hA5, 1'b1);
    chk("single_empty", 32'(empty), 32'd0);
    chk("single_count", 32'(data_count), 32'd1);
    rd_byte("single_dout", 8'hA5);
    chk("single_count_rd", 32'(data_count), 32'd0);
    chk("single_empty_rd", 32'(empty), 32'd1);

    // Glitch on the start bit.
    send_bit(1'b0, 4);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    send_bit(1'b1, 20);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    chk("glitch_empty", 32'(empty), 32'd1);
    chk("glitch_ferr", 32'(frame_err), 32'd0);
    chk("glitch_ovf", 32'(overflow), 32'd0);

    // Framing error with line held low.
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(i inside {2, 3, 4, 5}, 16);  // 0x3C
    send_bit(1'b0, 40);
    chk("ferr_flag", 32'(frame_err), 32'd1);
    chk("ferr_wait_busy", 32'(rx_busy), 32'd1);
    chk("ferr_empty", 32'(empty), 32'd1);
    send_bit(1'b1, 20);
    chk("ferr_idle", 32'(rx_busy), 32'd0);
    send_byte(8'h55, 1'b1);
    chk("ferr_next_count", 32'(data_count), 32'd1);
    rd_byte("ferr_next_dout", 8'h55);
    pulse_clr();
    chk("ferr_cleared", 32'(frame_err), 32'd0);

    // Overflow; clr_err lands in the overflow cycle and must lose.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count16", 32'(data_count), 32'd16);
    chk("ovf_pre", 32'(overflow), 32'd0);
    send_byte_evt(8'h10, 1'b1, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count_hold", 32'(data_count), 32'd16);
    for (int i = 0; i < 16; i++) rd_byte($sformatf("ovf_rd%0d", i), 8'(i));
    chk("ovf_empty", 32'(empty), 32'd1);
    chk("ovf_not_full", 32'(full), 32'd0);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Read in the push cycle with three bytes stored.
    send_byte(8'h20, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("simul_count_pre", 32'(data_count), 32'd3);
    send_byte_evt(8'h23, 1'b1, 1'b1);
    chk("simul_count_post", 32'(data_count), 32'd3);
    rd_byte("simul_rd1", 8'h21);
    rd_byte("simul_rd2", 8'h22);
    rd_byte("simul_rd3", 8'h23);
    chk("simul_empty", 32'(empty), 32'd1);

    // clr_err coincident with a new framing error.
    send_byte_evt(8'h3C, 1'b0, 1'b0);
    chk("ferr_clr_same", 32'(frame_err), 32'd1);
    send_bit(1'b1, 20);
    chk("ferr_clr_idle", 32'(rx_busy), 32'd0);
    pulse_clr();
    chk("ferr_clr_after", 32'(frame_err), 32'd0);

    // Reset during data bit 4, with one byte stored.
    send_byte(8'h77, 1'b1);
    chk("rstmid_count_pre", 32'(data_count), 32'd1);
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b0, 8);
    chk("rstmid_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    chk_reset_vals("rstmid");
    send_bit(1'b1, 20);
    send_byte(8'h81, 1'b1);
    chk("rstmid_count", 32'(data_count), 32'd1);
    rd_byte("rstmid_dout", 8'h81);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_ferr", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
